// File: rtl/timer_arbiter.sv
// Round-robin arbiter that shares one prescaled countdown timer among N_REQ requesters.
// The winner's delay is latched, counted down in prescaler ticks, and a one-cycle done pulse is returned.
module timer_arbiter #(
    parameter int N_REQ          = 3,
    parameter int PRESCALE_FINAL = 49999,
    parameter int DW             = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] delay,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    done,
    output logic                busy
);

    localparam int PW = (PRESCALE_FINAL > 0) ? $clog2(PRESCALE_FINAL + 1) : 1;
    localparam int IW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               busy_q, busy_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [DW-1:0]      rem_q, rem_d;
    logic [IW-1:0]      last_q, last_d;
    logic [IW-1:0]      owner_q, owner_d;

    logic [IW-1:0]      pick;
    logic               pick_vld;
    logic [DW-1:0]      pick_delay;
    logic [N_REQ-1:0]   pick_onehot;

    // Index k places after base, wrapping modulo N_REQ.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IW'(s);
    endfunction

    always_comb begin
        pick     = last_q;
        pick_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!pick_vld && req[rr_index(last_q, k)]) begin
                pick     = rr_index(last_q, k);
                pick_vld = 1'b1;
            end
        end
        pick_delay  = delay[int'(pick)*DW +: DW];
        pick_onehot = N_REQ'(1) << pick;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        pre_d   = pre_q;
        rem_d   = rem_q;
        last_d  = last_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    owner_d = pick;
                    grant_d = pick_onehot;
                    rem_d   = pick_delay;
                    pre_d   = '0;
                    if (pick_delay == '0) begin
                        state_d = DONE;
                        done_d  = pick_onehot;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // A dropped request abandons the timer before any tick is considered.
                if (!req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = owner_q;
                end else if (pre_q == PW'(PRESCALE_FINAL)) begin
                    pre_d = '0;
                    if (rem_q > DW'(1)) begin
                        rem_d = rem_q - DW'(1);
                    end else begin
                        state_d = DONE;
                        done_d  = grant_q;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                last_d  = owner_q;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            pre_q   <= '0;
            rem_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule
